// File: rtl/gate_share_pkg.sv
// Shared constants for the gate_share arbiter: opcode encoding and default sizing.
package gate_share_pkg;

    localparam int N_DEFAULT = 4;
    localparam int W_DEFAULT = 8;

    typedef logic [1:0] op_t;

    localparam op_t OP_AND  = 2'd0;
    localparam op_t OP_OR   = 2'd1;
    localparam op_t OP_XOR  = 2'd2;
    localparam op_t OP_NAND = 2'd3;

endpackage

// File: rtl/gate_share_arb_if.sv
// Bundle of requester-side and result-side signals of gate_share_arb.
interface gate_share_arb_if
    import gate_share_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int W = W_DEFAULT
);
    localparam int IW = $clog2(N);

    // Requester i holds req[i] with stable operands until it sees gnt[i] (one
    // cycle); a result transfers on a rising edge where rvalid && rready, and
    // y/rid/rvalid stay frozen while rvalid is high and rready is low.
    logic [N-1:0]   req;
    logic [N*W-1:0] a;
    logic [N*W-1:0] b;
    logic [N*2-1:0] op;
    logic [N-1:0]   gnt;
    logic           rvalid;
    logic           rready;
    logic [W-1:0]   y;
    logic [IW-1:0]  rid;
    logic [15:0]    count;

    modport master (
        output req, a, b, op, rready,
        input  gnt, rvalid, y, rid, count
    );

    modport slave (
        input  req, a, b, op, rready,
        output gnt, rvalid, y, rid, count
    );

endinterface

// File: rtl/gate_share_arb_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping.
module rr_pick
    import gate_share_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic          found
);

    int idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && eligible[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gate_share_arb.sv
// N requesters share one bitwise logic unit through a round-robin grant and a
// two-stage pipeline (S1 = captured operands, S2 = registered result).
module gate_share_arb
    import gate_share_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int W = W_DEFAULT
) (
    input logic              clk,
    input logic              rst_n,
    gate_share_arb_if.slave  bus
);

    localparam int IW = $clog2(N);

    logic [N-1:0]  eligible;
    logic [N-1:0]  winner;
    logic          found;
    logic          grant;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] ptr;

    logic          s1_full;
    logic [W-1:0]  s1_a;
    logic [W-1:0]  s1_b;
    op_t           s1_op;
    logic [IW-1:0] s1_id;

    logic [W-1:0]  result;
    logic [W-1:0]  y_q;
    logic [IW-1:0] rid_q;
    logic          rvalid_q;
    logic [N-1:0]  gnt_q;
    logic [15:0]   count_q;

    logic          s2_adv;
    logic          s1_accept;

    assign s2_adv    = !rvalid_q || bus.rready;
    assign s1_accept = !s1_full || s2_adv;
    // Masking with the current grant keeps a requester that is still holding
    // req in its grant cycle from being captured twice for one operation.
    assign eligible  = bus.req & ~gnt_q;
    assign grant     = s1_accept && found;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .eligible (eligible),
        .ptr      (ptr),
        .winner   (winner),
        .found    (found)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (winner[i]) win_idx = IW'(i);
        end
    end

    always_comb begin
        result = '0;
        case (s1_op)
            OP_AND:  result = s1_a & s1_b;
            OP_OR:   result = s1_a | s1_b;
            OP_XOR:  result = s1_a ^ s1_b;
            OP_NAND: result = ~(s1_a & s1_b);
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            s1_full  <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= OP_AND;
            s1_id    <= '0;
            y_q      <= '0;
            rid_q    <= '0;
            rvalid_q <= 1'b0;
            gnt_q    <= '0;
            count_q  <= '0;
        end else begin
            if (s2_adv) begin
                rvalid_q <= s1_full;
                if (s1_full) begin
                    y_q   <= result;
                    rid_q <= s1_id;
                end
            end

            // S1 either refills from the winner or empties once its contents move on.
            if (s1_accept) begin
                s1_full <= grant;
            end

            gnt_q <= grant ? winner : '0;

            if (grant) begin
                s1_a  <= bus.a[win_idx*W +: W];
                s1_b  <= bus.b[win_idx*W +: W];
                s1_op <= op_t'(bus.op[win_idx*2 +: 2]);
                s1_id <= win_idx;
                ptr   <= (win_idx == IW'(N-1)) ? '0 : win_idx + IW'(1);
            end

            if (rvalid_q && bus.rready) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.rvalid = rvalid_q;
    assign bus.y      = y_q;
    assign bus.rid    = rid_q;
    assign bus.count  = count_q;

endmodule

// File: tb/tb_gate_share_arb.sv
// Directed bench for gate_share_arb: hand-computed vectors, sampled on the falling edge.
module tb_gate_share_arb;

    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [W+1:0] exp_q[$];
    logic [W-1:0] fair_y [4] = '{8'h01, 8'h2F, 8'h4B, 8'hF7};
    logic [W-1:0] sweep_y [4] = '{8'h0A, 8'hAF, 8'hA5, 8'hF5};

    gate_share_arb_if #(.N(N), .W(W)) bus ();

    gate_share_arb #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_op(input int i, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [1:0] ov);
        bus.a[i*W +: W] = av;
        bus.b[i*W +: W] = bv;
        bus.op[i*2 +: 2] = ov;
    endtask

    task automatic check_res(input string tag, input logic [W-1:0] ey, input logic [1:0] erid);
        check({tag, "_rvalid"}, bus.rvalid, 1'b1);
        check({tag, "_y"}, bus.y, ey);
        check({tag, "_rid"}, bus.rid, erid);
    endtask

    // Scoreboard step: record the granted requester's expected result, retire
    // the result that the next edge will accept.
    task automatic sb_step();
        logic [W+1:0] e;
        for (int i = 0; i < N; i++) begin
            if (bus.gnt[i]) exp_q.push_back({2'(i), fair_y[i]});
        end
        if (bus.rvalid && bus.rready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_result", bus.y, 8'h00);
            end else begin
                e = exp_q.pop_front();
                check("sb_y", bus.y, e[W-1:0]);
                check("sb_rid", bus.rid, e[W+1:W]);
            end
        end
    endtask

    initial begin
        int cyc;
        rst_n      = 1'b0;
        bus.req    = '0;
        bus.a      = '0;
        bus.b      = '0;
        bus.op     = '0;
        bus.rready = 1'b0;

        // Reset state
        #2;
        check("rst_gnt", bus.gnt, 4'b0000);
        check("rst_rvalid", bus.rvalid, 1'b0);
        check("rst_y", bus.y, 8'h00);
        check("rst_rid", bus.rid, 2'd0);
        check("rst_count", bus.count, 16'h0000);
        tick();
        rst_n = 1'b1;

        // Single request
        set_op(0, 8'hF0, 8'h3C, 2'd0);
        bus.req    = 4'b0001;
        bus.rready = 1'b1;
        tick();
        check("single_gnt", bus.gnt, 4'b0001);
        check("single_rvalid_early", bus.rvalid, 1'b0);
        check("single_count_idle", bus.count, 16'd0);
        bus.req = 4'b0000;
        tick();
        check("single_gnt_drop", bus.gnt, 4'b0000);
        check_res("single", 8'h30, 2'd0);
        tick();
        check("single_count", bus.count, 16'd1);
        check("single_rvalid_done", bus.rvalid, 1'b0);

        // Opcode sweep on requester 2
        for (int o = 0; o < 4; o++) begin
            set_op(2, 8'hAA, 8'h0F, 2'(o));
            bus.req = 4'b0100;
            tick();
            check($sformatf("sweep%0d_gnt", o), bus.gnt, 4'b0100);
            bus.req = 4'b0000;
            tick();
            check_res($sformatf("sweep%0d", o), sweep_y[o], 2'd2);
            tick();
        end
        check("sweep_count", bus.count, 16'd5);

        // Fairness with all four requesters, after a fresh reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_op(0, 8'h11, 8'h0F, 2'd0);
        set_op(1, 8'h22, 8'h0F, 2'd1);
        set_op(2, 8'h44, 8'h0F, 2'd2);
        set_op(3, 8'h88, 8'h0F, 2'd3);
        bus.req = 4'b1111;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("fair_gnt%0d", k), bus.gnt, 32'(1) << ((k - 1) % 4));
            sb_step();
            bus.req = (k < 8) ? ~(4'(1) << ((k - 1) % 4)) : 4'b0000;
        end
        tick();
        sb_step();
        tick();
        check("fair_count", bus.count, 16'd8);
        check("fair_rvalid_done", bus.rvalid, 1'b0);
        check("fair_sb_empty", exp_q.size(), 0);

        // Backpressure: S2 stalls, S1 fills once, further requests ignored
        set_op(0, 8'hF0, 8'h3C, 2'd1);
        set_op(1, 8'h55, 8'hFF, 2'd2);
        bus.req    = 4'b0011;
        bus.rready = 1'b0;
        tick();
        check("bp_gnt1", bus.gnt, 4'b0001);
        bus.req = 4'b0010;
        tick();
        check("bp_gnt2", bus.gnt, 4'b0010);
        check_res("bp_first", 8'hFC, 2'd0);
        set_op(0, 8'h0F, 8'h0F, 2'd3);
        bus.req = 4'b0001;
        for (int k = 3; k <= 5; k++) begin
            tick();
            check($sformatf("bp_stall_gnt%0d", k), bus.gnt, 4'b0000);
            check_res($sformatf("bp_stall%0d", k), 8'hFC, 2'd0);
            check($sformatf("bp_stall_count%0d", k), bus.count, 16'd8);
        end
        bus.rready = 1'b1;
        tick();
        check("bp_regrant", bus.gnt, 4'b0001);
        check_res("bp_drain1", 8'hAA, 2'd1);
        check("bp_count1", bus.count, 16'd9);
        bus.req = 4'b0000;
        tick();
        check("bp_gnt_idle", bus.gnt, 4'b0000);
        check_res("bp_drain2", 8'hF0, 2'd0);
        check("bp_count2", bus.count, 16'd10);
        tick();
        check("bp_rvalid_done", bus.rvalid, 1'b0);
        check("bp_count3", bus.count, 16'd11);

        // Reset while S1 and S2 are both full
        set_op(1, 8'h5A, 8'hA5, 2'd2);
        set_op(2, 8'h12, 8'h34, 2'd1);
        bus.req    = 4'b0110;
        bus.rready = 1'b0;
        tick();
        check("mid_gnt1", bus.gnt, 4'b0010);
        bus.req = 4'b0100;
        tick();
        check("mid_gnt2", bus.gnt, 4'b0100);
        check_res("mid_full", 8'hFF, 2'd1);
        bus.req = 4'b0000;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_gnt", bus.gnt, 4'b0000);
        check("mid_rst_rvalid", bus.rvalid, 1'b0);
        check("mid_rst_y", bus.y, 8'h00);
        check("mid_rst_rid", bus.rid, 2'd0);
        check("mid_rst_count", bus.count, 16'h0000);
        set_op(1, 8'hC3, 8'h3C, 2'd1);
        set_op(3, 8'hFF, 8'h81, 2'd0);
        bus.req    = 4'b1010;
        bus.rready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_gnt1", bus.gnt, 4'b0010);
        check("post_rst_count0", bus.count, 16'd0);
        bus.req = 4'b1000;
        tick();
        check("post_rst_gnt2", bus.gnt, 4'b1000);
        check_res("post_rst_r1", 8'hFF, 2'd1);
        bus.req = 4'b0000;
        tick();
        check_res("post_rst_r3", 8'h81, 2'd3);
        check("post_rst_count1", bus.count, 16'd1);
        tick();
        check("post_rst_count2", bus.count, 16'd2);

        // Count wrap: two alternating requesters keep one result per cycle
        set_op(0, 8'h01, 8'h01, 2'd0);
        set_op(1, 8'h02, 8'h02, 2'd1);
        bus.req = 4'b0011;
        cyc = 0;
        while (bus.count !== 16'hFFFF && cyc < 70000) begin
            tick();
            cyc++;
        end
        check("wrap_reach", bus.count, 16'hFFFF);
        check("wrap_rvalid", bus.rvalid, 1'b1);
        bus.req = 4'b0000;
        tick();
        check("wrap_count", bus.count, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gate_share_arb.md
GATE_SHARE_ARB -- requirements
Module: gate_share_arb

Interface
REQ-001 Parameter N, default 4, number of requesters sharing the logic unit (2..8).
REQ-002 Parameter W, default 8, operand and result width in bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 req  input  N  per-requester request; held high with operands stable until the matching gnt bit is seen.
REQ-006 a  input  N*W  per-requester operand A; requester i uses slice [i*W +: W].
REQ-007 b  input  N*W  per-requester operand B; same slicing as a.
REQ-008 op  input  N*2  per-requester opcode; slice [i*2 +: 2]: 0 AND, 1 OR, 2 XOR, 3 NAND.
REQ-009 gnt  output  N  one-hot grant; high for exactly one cycle when the requester's operands are captured.
REQ-010 rvalid  output  1  result valid.
REQ-011 rready  input  1  downstream accepts the result when rvalid and rready are both high at a rising edge.
REQ-012 y  output  W  registered result.
REQ-013 rid  output  clog2(N)  index of the requester that owns y.
REQ-014 count  output  16  number of results accepted downstream; wraps 0xFFFF to 0x0000.

Function
REQ-015 Two pipeline stages: S1 holds captured {a, b, op, id}; S2 holds {y, rid} and drives rvalid.
REQ-016 S2 advances when rvalid is 0 or rready is 1; otherwise y, rid and rvalid hold unchanged.
REQ-017 S1 accepts a new capture when S1 is empty or S2 advances.
REQ-018 At an edge where S1 accepts and at least one eligible req is high, the round-robin winner is captured into S1 and gnt is set to its one-hot bit for the following cycle; otherwise gnt is 0.
REQ-019 Eligible means req[i]=1 and gnt[i]=0 in the current cycle, so a requester still holding req in its grant cycle is not granted twice for one operation.
REQ-020 Round-robin order: search starts at index ptr and wraps to ptr-1; after a grant to i, ptr becomes (i+1) mod N; ptr is unchanged when nothing is granted.
REQ-021 Result is computed from S1 contents, bitwise across all W bits, and loaded into S2 when S2 advances and S1 is full; S1 empties unless it is refilled at the same edge.
REQ-022 Latency: request sampled at edge k gives gnt high in cycle k..k+1 and rvalid high after edge k+1, with no stall.
REQ-023 Throughput: one result per cycle when different requesters alternate; a single requester gets at most one grant every 2 cycles.
REQ-024 When S2 is stalled and S1 is full, no grants are issued and all req lines are ignored.
REQ-025 count increments by 1 at each edge where rvalid and rready are both high.
REQ-026 If rready is high while rvalid is low, nothing happens and count does not change.

Reset
REQ-027 While rst_n is low: gnt=0, rvalid=0, y=0, rid=0, count=0, S1 empty, ptr=0; an operation in flight is discarded and is not counted.
REQ-028 The first grant can occur at the first rising edge after rst_n deasserts.

Structure
REQ-029 Shared package gate_share_pkg holds the opcode constants (OP_AND, OP_OR, OP_XOR, OP_NAND), the 2-bit op type, and the defaults for N and W.
REQ-030 One sub-module, rr_pick: combinational round-robin picker with inputs eligible[N] and ptr, and outputs one-hot winner and found.
REQ-031 The bitwise logic unit is inline in gate_share_arb; it has no separate module.

Verification
REQ-032 Single request: N=4, W=8, req=0001, a0=0xF0, b0=0x3C, op0=AND, rready=1 -> gnt=0001 for one cycle; next cycle rvalid=1, y=0x30, rid=0, count=1.
REQ-033 Opcode sweep: requester 2, a=0xAA, b=0x0F, op 0/1/2/3 in turn -> y=0x0A, 0xAF, 0xA5, 0xF5, each with rid=2.
REQ-034 Fairness: req=1111 held continuously, each requester dropping and re-raising after its grant -> grant order 0,1,2,3,0,...; no requester granted twice in consecutive cycles.
REQ-035 Backpressure: rready=0 for 5 cycles with req=0011 -> y and rid stable, exactly one additional grant (S1 fills), then gnt=0; after rready=1, results drain in order and count increments by the number accepted.
REQ-036 Reset mid-operation: assert rst_n low while S1 and S2 are full -> all outputs 0 immediately (asynchronous); after release, count=0 and the next grant goes to the lowest-index requester.
REQ-037 Wrap: preload count to 0xFFFF (force or run 65535 ops), complete one handshake -> count=0x0000.
